karatsuba_mul_seq: RTL and testbench

//  Sequencer that computes a wide unsigned product (18*LIMBS x 18*LIMBS) on one shared

---
 rtl/karatsuba_mul_seq_if.sv | 28 ++
 rtl/karatsuba_mul_seq.sv | 131 +++++++++++++
 tb/tb_karatsuba_mul_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/karatsuba_mul_seq_if.sv
// Front-end bundle between the FPU and the wide-multiply sequencer:
// operand offer (valid/ready), flush, and product return (valid/ready).
interface karatsuba_mul_seq_if #(
    parameter int unsigned LIMBS = 3
);
    localparam int unsigned W = 18 * LIMBS;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           kill;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    // FPU side
    modport master (
        output in_valid, in_a, in_b, kill, out_ready,
        input  in_ready, out_valid, out_p
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, kill, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/karatsuba_mul_seq.sv
// Wide unsigned multiplier built from LIMBS^2 18x18 partial products issued one at a
// time to a shared karatsuba_18b core and shift-accumulated into a 2W-bit product.
module karatsuba_mul_seq #(
    parameter int unsigned LIMBS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    karatsuba_mul_seq_if.slave  bus,
    output logic                busy,
    output logic                m_start,
    output logic [17:0]         m_a,
    output logic [17:0]         m_b,
    input  logic [35:0]         m_s,
    input  logic                m_done
);
    localparam int unsigned W    = 18 * LIMBS;
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned IdxW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(LIMBS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StResp  = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IdxW-1:0] i_q, i_d;
    logic [IdxW-1:0] j_q, j_d;
    logic [PW-1:0]   acc_q, acc_d;

    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [PW-1:0]   pp_ext;
    logic [PW-1:0]   pp_shifted;
    logic            last_pair;

    // Limb operands follow the indices, which only move on m_done, so they stay
    // stable from ISSUE through the end of WAIT.
    assign a_sh = a_q >> (18 * i_q);
    assign b_sh = b_q >> (18 * j_q);
    assign m_a  = a_sh[17:0];
    assign m_b  = b_sh[17:0];

    assign pp_ext     = PW'(m_s);
    assign pp_shifted = pp_ext << (18 * (i_q + j_q));
    assign last_pair  = (i_q == LastIdx) && (j_q == LastIdx);

    assign m_start       = (state_q == StIssue);
    assign busy          = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StResp);
    assign bus.out_p     = acc_q;

    // Next-state: accept, issue/wait loop over limb pairs, respond, or drain on kill.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            StIdle: begin
                // kill wins over a same-cycle offer
                if (bus.in_valid && !bus.kill) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // The core has seen start either way; a kill must still wait for it.
                state_d = bus.kill ? StDrain : StWait;
            end
            StWait: begin
                if (bus.kill) begin
                    state_d = StDrain;
                end else if (m_done) begin
                    acc_d = acc_q + pp_shifted;
                    if (last_pair) begin
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                        if (j_q == LastIdx) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            StResp: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (m_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Directed and randomized bench for karatsuba_mul_seq with a behavioural 18x18 core.
module tb_karatsuba_mul_seq;
    localparam int unsigned LIMBS = 3;
    localparam int          LAT   = 2;
    localparam int          EXP_LAT = LIMBS * LIMBS * (2 + LAT) + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic        m_start;
    logic [17:0] m_a;
    logic [17:0] m_b;
    logic [35:0] m_s;
    logic        m_done;

    karatsuba_mul_seq_if #(.LIMBS(LIMBS)) bus ();

    karatsuba_mul_seq #(.LIMBS(LIMBS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .m_start (m_start),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_s     (m_s),
        .m_done  (m_done)
    );

    always #5 clk = ~clk;

    // Core model: clears done on start, raises it LAT cycles later; not reset by rst_n.
    logic        core_done = 1'b0;
    logic [35:0] core_s    = '0;
    logic [17:0] core_a    = '0;
    logic [17:0] core_b    = '0;
    int          core_cnt  = 0;
    assign m_done = core_done;
    assign m_s    = core_s;

    always @(posedge clk) begin
        if (m_start) begin
            core_done <= 1'b0;
            core_cnt  <= LAT;
            core_a    <= m_a;
            core_b    <= m_b;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done <= 1'b1;
                core_s    <= 36'(core_a) * 36'(core_b);
            end
        end
    end

    // Monitor: start count, limb log, handshakes, core-protocol violations.
    int          start_cnt = 0;
    int          out_hs    = 0;
    int          proto_err = 0;
    logic [35:0] log_ab [64];

    always @(posedge clk) begin
        if (m_start) begin
            start_cnt <= start_cnt + 1;
            log_ab[start_cnt % 64] <= {m_a, m_b};
            if (core_cnt != 0) proto_err <= proto_err + 1;
        end
        if (rst_n && core_cnt != 0 && !m_start && (m_a !== core_a || m_b !== core_b))
            proto_err <= proto_err + 1;
        if (bus.out_valid && bus.out_ready) out_hs <= out_hs + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 500) begin
            tick();
            n++;
        end
        check(tag, bus.in_ready, 1'b1);
    endtask

    task automatic send(input logic [53:0] a, input logic [53:0] b);
        wait_ready("in_ready_before_send");
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // lat counts the accept cycle, so it matches accept-to-out_valid latency.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 1000) begin
            tick();
            lat++;
        end
        check("out_valid_seen", bus.out_valid, 1'b1);
    endtask

    task automatic take(input int hold);
        for (int k = 0; k < hold; k++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int           s0;
        int           hs0;
        int           lat;
        logic [63:0]  r64;
        logic [53:0]  ra;
        logic [53:0]  rb;
        logic [107:0] ref_p;
        logic         do_kill;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("por_in_ready", bus.in_ready, 1'b1);
        check("por_out_valid", bus.out_valid, 1'b0);
        check("por_out_p", bus.out_p, 108'd0);
        check("por_busy", busy, 1'b0);
        check("por_m_start", m_start, 1'b0);
        check("por_m_ab", {m_a, m_b}, 36'd0);
        rst_n = 1'b1;

        // 1. Reset mid-WAIT, then a clean op despite the core's stale done
        send(54'h2A_BCDE_F012_3456, 54'h15_4321_0FED_CBA9);
        tick();
        tick();
        check("t1_in_wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        repeat (3) tick();
        check("t1_rst_in_ready", bus.in_ready, 1'b1);
        check("t1_rst_out_valid", bus.out_valid, 1'b0);
        check("t1_rst_out_p", bus.out_p, 108'd0);
        check("t1_rst_m_start", m_start, 1'b0);
        check("t1_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        s0  = start_cnt;
        hs0 = out_hs;
        send(54'd123456789, 54'd987654321);
        wait_out(lat);
        check("t1_out_p", bus.out_p, 108'd121932631112635269);
        check("t1_latency", lat, EXP_LAT);
        take(0);
        check("t1_after_out_valid", bus.out_valid, 1'b0);
        check("t1_after_in_ready", bus.in_ready, 1'b1);
        check("t1_starts", start_cnt - s0, 9);

        // 2. All-ones operands
        s0  = start_cnt;
        hs0 = out_hs;
        send(54'h3F_FFFF_FFFF_FFFF, 54'h3F_FFFF_FFFF_FFFF);
        wait_out(lat);
        check("t2_out_p", bus.out_p, {53'h1F_FFFF_FFFF_FFFF, 54'd0, 1'b1});
        take(0);
        check("t2_starts", start_cnt - s0, 9);
        check("t2_handshakes", out_hs - hs0, 1);

        // 3. Limb issue order
        s0 = start_cnt;
        send(54'h3FFFF, 54'h1 << 36);
        wait_out(lat);
        check("t3_out_p", bus.out_p, 108'h3_FFFF_0000_0000_0);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t3_limb_%0d_%0d", k / 3, k % 3), log_ab[(s0 + k) % 64],
                  {((k / 3) == 0) ? 18'h3FFFF : 18'h0, ((k % 3) == 2) ? 18'h1 : 18'h0});
        end
        take(0);

        // 4. Backpressure: result holds, new offer refused
        s0  = start_cnt;
        hs0 = out_hs;
        send(54'd3, 54'd4);
        wait_out(lat);
        bus.in_valid = 1'b1;
        bus.in_a     = 54'd9;
        bus.in_b     = 54'd9;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_out_p", bus.out_p, 108'd12);
            check("t4_hold_out_valid", bus.out_valid, 1'b1);
            check("t4_hold_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t4_out_valid_falls", bus.out_valid, 1'b0);
        check("t4_in_ready_back", bus.in_ready, 1'b1);
        check("t4_handshakes", out_hs - hs0, 1);
        check("t4_no_accept", start_cnt - s0, 9);

        // 5. Kill during WAIT of the 4th partial
        s0  = start_cnt;
        hs0 = out_hs;
        send(54'h123, 54'h456);
        for (int n = 0; n < 500 && (start_cnt - s0) < 4; n++) tick();
        check("t5_reached_4th", start_cnt - s0, 4);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check("t5_drain_in_ready", bus.in_ready, 1'b0);
        check("t5_drain_busy", busy, 1'b1);
        check("t5_drain_m_start", m_start, 1'b0);
        wait_ready("t5_idle_after_drain");
        check("t5_no_out", out_hs - hs0, 0);
        check("t5_starts", start_cnt - s0, 4);
        send(54'd5, 54'd7);
        wait_out(lat);
        check("t5_next_out_p", bus.out_p, 108'd35);
        take(0);

        // 6. Random operands with backpressure and occasional kill
        for (int n = 0; n < 1000; n++) begin
            r64     = {$urandom(), $urandom()};
            ra      = r64[53:0];
            r64     = {$urandom(), $urandom()};
            rb      = r64[53:0];
            do_kill = ($urandom_range(15) == 0);
            s0      = start_cnt;
            hs0     = out_hs;
            send(ra, rb);
            if (do_kill) begin
                repeat ($urandom_range(30)) tick();
                bus.kill = 1'b1;
                tick();
                bus.kill = 1'b0;
                wait_ready("rnd_kill_idle");
                check("rnd_kill_no_out", out_hs - hs0, 0);
            end else begin
                wait_out(lat);
                ref_p = 108'(ra) * 108'(rb);
                check("rnd_out_p", bus.out_p, ref_p);
                take($urandom_range(2));
                check("rnd_starts", start_cnt - s0, 9);
                check("rnd_one_out", out_hs - hs0, 1);
            end
        end

        check("core_protocol", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
